// File: rtl/weight_serializer.sv
// Parallel-to-serial feeder for the bit-serial neuron multiplier.
// Words are accepted into a one-word holding register and streamed LSB first.
// The holding register lets the next word load on the edge after the previous
// word's last bit, so back-to-back words stream without a gap.
//
// state | meaning
// IDLE  | nothing streaming; loads the shift register as soon as the hold is full
// SHIFT | presenting shift_q[0]; advances one bit per unstalled cycle
//
// CNT_W must satisfy 2**CNT_W >= WIDTH.
module weight_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] weight_in,
    input  logic             weight_valid,
    output logic             weight_ready,
    input  logic             stall,
    output logic             Weight_bit,
    output logic             enable,
    output logic             word_start,
    output logic             word_last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic               hold_full_q;
    logic [WIDTH-1:0]   hold_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   bit_cnt_q;

    // Handshake capture, shift-register load/reload and bit stepping.
    // A capture and a reload never coincide because ready is low while the
    // hold is full; the capture is written first so the clear below wins only
    // in the impossible overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            if (weight_valid && !hold_full_q) begin
                hold_q      <= weight_in;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
                        hold_full_q <= 1'b0;
                        bit_cnt_q   <= '0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!stall) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (hold_full_q) begin
                                shift_q     <= hold_q;
                                hold_full_q <= 1'b0;
                                bit_cnt_q   <= '0;
                            end else begin
                                // Shifting out the final bit leaves the register
                                // all zero, so Weight_bit rests at 0 while idle.
                                shift_q   <= {1'b0, shift_q[WIDTH-1:1]};
                                bit_cnt_q <= '0;
                                state_q   <= IDLE;
                            end
                        end else begin
                            shift_q   <= {1'b0, shift_q[WIDTH-1:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stream outputs; only stall reaches them combinationally.
    always_comb begin
        weight_ready = !hold_full_q;
        Weight_bit   = shift_q[0];
        enable       = (state_q == SHIFT) && !stall;
        word_start   = enable && (bit_cnt_q == '0);
        word_last    = enable && (bit_cnt_q == LAST_BIT);
        busy         = (state_q == SHIFT) || hold_full_q;
    end

endmodule

// File: tb/tb_weight_serializer.sv
// Bench for weight_serializer: a word-level model (pending word + current word
// indexed by bit position) is checked against every output each cycle, and the
// words reassembled from the serial stream are checked against literals.
module tb_weight_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] weight_in;
    logic         weight_valid;
    logic         weight_ready;
    logic         stall;
    logic         Weight_bit;
    logic         enable;
    logic         word_start;
    logic         word_last;
    logic         busy;

    weight_serializer #(.WIDTH(W), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .weight_in    (weight_in),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .stall        (stall),
        .Weight_bit   (Weight_bit),
        .enable       (enable),
        .word_start   (word_start),
        .word_last    (word_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- word-level model ----------------
    bit         started = 1'b0;
    bit         m_active = 1'b0;
    logic [W-1:0] m_word = '0;
    int         m_k = 0;
    bit         m_hold_v = 1'b0;
    logic [W-1:0] m_hold_w = '0;
    bit         m_acc;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            m_hold_v = 1'b0;
            m_k      = 0;
            started  = 1'b1;
        end else begin
            m_acc = weight_valid && !m_hold_v;
            if (!m_active) begin
                if (m_hold_v) begin
                    m_active = 1'b1;
                    m_word   = m_hold_w;
                    m_k      = 0;
                    m_hold_v = 1'b0;
                end
            end else if (!stall) begin
                if (m_k == W - 1) begin
                    if (m_hold_v) begin
                        m_word   = m_hold_w;
                        m_k      = 0;
                        m_hold_v = 1'b0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_k++;
                end
            end
            if (m_acc) begin
                m_hold_v = 1'b1;
                m_hold_w = weight_in;
            end
        end
    end

    // ---------------- compare + stream collector ----------------
    logic [W-1:0] col_acc;
    int           col_idx;
    int           col_st;
    logic [W-1:0] words_q[$];
    int           st_q[$];
    int           end_q[$];
    int           en_cnt = 0;

    always @(negedge clk) begin
        #4;
        if (started) begin
            chk("weight_ready", int'(weight_ready), int'(!m_hold_v));
            chk("enable",       int'(enable),       int'(m_active && !stall));
            chk("Weight_bit",   int'(Weight_bit),   m_active ? int'((m_word >> m_k) & 1) : 0);
            chk("word_start",   int'(word_start),   int'(m_active && !stall && m_k == 0));
            chk("word_last",    int'(word_last),    int'(m_active && !stall && m_k == W - 1));
            chk("busy",         int'(busy),         int'(m_active || m_hold_v));
            if (enable === 1'b1) begin
                en_cnt++;
                if (word_start) begin
                    col_acc = '0;
                    col_idx = 0;
                    col_st  = cyc;
                end
                if (col_idx < W) col_acc[col_idx] = Weight_bit;
                col_idx++;
                if (word_last) begin
                    words_q.push_back(col_acc);
                    st_q.push_back(col_st);
                    end_q.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic [W-1:0] w, output int hc);
        int  n;
        bit  acc;
        weight_valid = 1'b1;
        weight_in    = w;
        n  = 0;
        hc = -1;
        forever begin
            #4;
            acc = weight_ready;
            hc  = cyc;
            @(negedge clk);
            if (acc) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        weight_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (words_q.size() < n) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                chk("wait_words_timeout", words_q.size(), n);
                break;
            end
        end
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            #4;
            if (enable && word_start) break;
            t++;
            if (t > 100) begin
                chk("wait_start_timeout", 0, 1);
                break;
            end
        end
    endtask

    int h0, h1, h2, base, en0;

    initial begin
        reset        = 1'b1;
        weight_valid = 1'b0;
        weight_in    = '0;
        stall        = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_ready", int'(weight_ready), 1);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_bit",   int'(Weight_bit), 0);
        @(negedge clk);
        reset = 1'b0;

        // single word 0x1111
        en0 = en_cnt;
        send(16'h1111, h0);
        wait_words(1);
        repeat (3) @(negedge clk);
        chk("w1_word",    int'(words_q[0]), 16'h1111);
        chk("w1_latency", st_q[0] - h0, 2);
        chk("w1_enables", en_cnt - en0, 16);
        chk("w1_span",    end_q[0] - st_q[0] + 1, 16);

        // back-to-back 0x1111, 0x8001
        send(16'h1111, h0);
        send(16'h8001, h1);
        wait_words(3);
        repeat (3) @(negedge clk);
        chk("b2b_w0",  int'(words_q[1]), 16'h1111);
        chk("b2b_w1",  int'(words_q[2]), 16'h8001);
        chk("b2b_gap", st_q[2], end_q[1] + 1);

        // three words offered continuously
        send(16'h1234, h0);
        send(16'hABCD, h1);
        send(16'h0F0F, h2);
        wait_words(6);
        repeat (3) @(negedge clk);
        chk("three_a", int'(words_q[3]), 16'h1234);
        chk("three_b", int'(words_q[4]), 16'hABCD);
        chk("three_c", int'(words_q[5]), 16'h0F0F);
        chk("three_hs_c", h2, st_q[4]);
        chk("three_gap",  st_q[5], end_q[4] + 1);

        // stall for 3 cycles on bit 5 of 0x00F0
        send(16'h00F0, h0);
        wait_start();
        repeat (5) @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_words(7);
        repeat (3) @(negedge clk);
        chk("stall_word", int'(words_q[6]), 16'h00F0);
        chk("stall_span", end_q[6] - st_q[6] + 1, 19);

        // reset at bit 7 of 0xFFFF with 0x5555 held
        send(16'hFFFF, h0);
        send(16'h5555, h1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #4;
        chk("rst_mid_enable", int'(enable), 0);
        chk("rst_mid_busy",   int'(busy), 0);
        chk("rst_mid_ready",  int'(weight_ready), 1);
        @(negedge clk);
        base = words_q.size();
        send(16'h0001, h0);
        wait_words(base + 1);
        repeat (20) @(negedge clk);
        chk("rst_count", words_q.size(), base + 1);
        chk("rst_word",  int'(words_q[base]), 16'h0001);

        // toggling valid with an idle cycle between words
        send(16'hA5A5, h0);
        @(negedge clk);
        send(16'h3C3C, h0);
        @(negedge clk);
        send(16'h8000, h0);
        wait_words(base + 4);
        repeat (3) @(negedge clk);
        chk("tog_w0", int'(words_q[base + 1]), 16'hA5A5);
        chk("tog_w1", int'(words_q[base + 2]), 16'h3C3C);
        chk("tog_w2", int'(words_q[base + 3]), 16'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_serializer.md
Name: weight_serializer

Overview:
- Upstream feeder for the bit-serial neuron multiplier.
- Accepts parallel WIDTH-bit weight words from weight memory over a valid/ready handshake.
- Streams each word one bit per cycle, LSB first, on Weight_bit, with a matching enable and word framing strobes.
- A one-word holding register gives gap-free back-to-back streaming.

Parameters:
- WIDTH, 16, bits per weight word; also the stream length per word.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- weight_in  input  WIDTH  parallel weight word from memory.
- weight_valid  input  1  weight_in holds a valid word.
- weight_ready  output  1  serializer can accept a word this cycle.
- stall  input  1  downstream hold; freezes the stream.
- Weight_bit  output  1  current serial weight bit to the multiplier.
- enable  output  1  Weight_bit is valid; drives the multiplier enable.
- word_start  output  1  high during the first (bit 0) cycle of each word.
- word_last  output  1  high during the last (bit WIDTH-1) cycle of each word.
- busy  output  1  a word is streaming or the holding register is full.

Behaviour:
- Reset, sampled at a clk edge with reset=1: clears state to IDLE, hold_full=0, shift register=0, bit_cnt=0.
  - Output values in that cycle: Weight_bit=0, enable=0, word_start=0, word_last=0, busy=0, weight_ready=1.
  - Reset overrides every other input, including mid-word. The partial word and the held word are discarded, not resumed.
- Handshake:
  - weight_ready = !hold_full (a function of state only; no combinational path from weight_valid).
  - Transfer occurs on an edge where weight_valid && weight_ready. weight_in is captured into hold_reg and hold_full is set.
- FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on an edge where hold_full=1. This load copies hold_reg into the shift register, clears hold_full and sets bit_cnt=0.
  - SHIFT with stall=0 and bit_cnt<WIDTH-1: shift register shifts right by one, bit_cnt increments.
  - SHIFT with stall=0 and bit_cnt==WIDTH-1:
    - If hold_full=1: reload from hold_reg, bit_cnt=0, stay in SHIFT. No bubble between words.
    - Else: go to IDLE.
  - SHIFT with stall=1: shift register, bit_cnt and state hold. A pending reload also waits.
- Simultaneous reload and handshake: not possible, because weight_ready=0 while hold_full=1. The hold refills at the earliest on the edge after a reload, which is well before the next reload (WIDTH>=2).
- Outputs:
  - Weight_bit = shift_reg[0].
  - enable = (state==SHIFT) && !stall.
  - word_start = enable && bit_cnt==0.
  - word_last = enable && bit_cnt==WIDTH-1.
  - busy = (state==SHIFT) || hold_full.
  - All outputs except weight_ready depend combinationally on stall only.
- Latency, from an empty idle block:
  - Handshake at edge N; hold loads into the shift register at edge N+1.
  - Bit 0 is presented with enable=1 in the cycle after N+1.
  - A word then occupies exactly WIDTH enabled cycles, plus one extra cycle per stalled cycle.
- Bit order: strictly LSB first. Bit k of the word is presented on the k-th enabled cycle of that word.
- Arithmetic: bit_cnt is unsigned and never exceeds WIDTH-1; there is no wrap beyond that. The shift register fills 0 at its MSB.

Test Plan:
- Reset, then a single word 0x1111 -> enable high for 16 consecutive cycles. Weight_bit sequence 1,0,0,0 repeated four times. word_start on cycle 1 only, word_last on cycle 16 only. busy falls to 0 after the last bit; weight_ready stays 1 once the hold is consumed.
- Back-to-back 0x1111 then 0x8001, weight_valid held high -> 32 consecutive enable cycles with no gap. The second word streams 1, then 14 zeros, then 1. weight_ready is low while the second word waits in the hold.
- Three words offered continuously -> the third word's handshake completes only on the edge after the second word loads into the shift register. Its first bit appears immediately after the second word's word_last.
- stall high for 3 cycles during bit 5 of 0x00F0 -> enable low for those 3 cycles. Weight_bit still shows bit 5 throughout. The stream resumes with bit 5 and the word completes after 19 cycles total.
- reset pulse at bit 7 of 0xFFFF with a second word held -> next cycle enable=0, busy=0, weight_ready=1. The held word is not emitted; a new word 0x0001 streams correctly afterwards.
- weight_valid toggling with one idle cycle between words -> each word is emitted intact with word_start/word_last framing. Bits never interleave across words.
